// File: rtl/full_adder_unit.sv
// full_adder_unit: ripple chain of single-bit full-adder cells with registered
// sum, carry-out and signed overflow, one cycle after a valid input.
`default_nettype none

module full_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic             r_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_ovf;

  assign w_carry[0] = c_in;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign w_sum[i]       = a[i] ^ b[i] ^ w_carry[i];
      assign w_carry[i + 1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
    end
  endgenerate

  // Result registers hold their value across idle cycles; only the valid flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_c_out <= w_carry[WIDTH];
        r_ovf   <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
      end
    end
  end

  assign out_valid = r_valid;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_full_adder_unit.sv
// Directed and random checks of full_adder_unit at WIDTH = 1, 8 and 16.
`default_nettype none

module tb_full_adder_unit;

  logic clk;
  logic rst_n;

  logic       v1, a1, b1, c1;
  logic       ov1, s1, co1, of1;

  logic       v8, c8;
  logic [7:0] a8, b8;
  logic       ov8, co8, of8;
  logic [7:0] s8;

  logic        v16, c16;
  logic [15:0] a16, b16;
  logic        ov16, co16, of16;
  logic [15:0] s16;

  int total;
  int bad;

  // {a, b, c_in} and required {c_out, sum, ovf} for the WIDTH=1 truth table
  localparam logic [2:0] VEC [8] = '{3'b000, 3'b100, 3'b010, 3'b001,
                                     3'b110, 3'b011, 3'b101, 3'b111};
  localparam logic [2:0] EXP [8] = '{3'b000, 3'b010, 3'b010, 3'b011,
                                     3'b101, 3'b100, 3'b100, 3'b110};

  full_adder_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c_in(c1),
    .out_valid(ov1), .sum(s1), .c_out(co1), .ovf(of1)
  );

  full_adder_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .c_in(c8),
    .out_valid(ov8), .sum(s8), .c_out(co8), .ovf(of8)
  );

  full_adder_unit #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .c_in(c16),
    .out_valid(ov16), .sum(s16), .c_out(co16), .ovf(of16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if ({ov1, co1, s1, of1, ov8, co8, of8, s8, ov16, co16, of16, s16} !== '0) begin
      bad++;
      $display("FAIL reset_state: w1=%b%b%b%b w8=%b%b%b/%h w16=%b%b%b/%h required all zero",
               ov1, co1, s1, of1, ov8, co8, of8, s8, ov16, co16, of16, s16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if ({ov1, ov8, ov16} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset: out_valid=%b%b%b required 000", ov1, ov8, ov16);
    end
  endtask

  task automatic test_truth_table();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] vec;
      logic [2:0] exp;
      vec = VEC[i];
      exp = EXP[i];
      {a1, b1, c1} = vec;
      v1 = 1'b1;
      tick();
      total++;
      if ({ov1, co1, s1, of1} !== {1'b1, exp}) begin
        bad++;
        $display("FAIL truth_%b: got v/co/s/ovf=%b%b%b%b required 1%b", vec, ov1, co1, s1, of1, exp);
      end
    end
    v1 = 1'b0;
  endtask

  task automatic test_async_reset();
    {a1, b1, c1} = 3'b111;
    v1 = 1'b1;
    tick();
    total++;
    if ({ov1, co1} !== 2'b11) begin
      bad++;
      $display("FAIL pre_reset: got v/co=%b%b required 11", ov1, co1);
    end
    v1 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({ov1, co1, s1, of1} !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset: got v/co/s/ovf=%b%b%b%b required 0000", ov1, co1, s1, of1);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({ov1, co1, s1} !== 3'b000) begin
        bad++;
        $display("FAIL post_release_%0d: got v/co/s=%b%b%b required 000", i, ov1, co1, s1);
      end
    end
    {a1, b1, c1} = 3'b100;
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    total++;
    if ({ov1, co1, s1} !== 3'b101) begin
      bad++;
      $display("FAIL first_capture: got v/co/s=%b%b%b required 101", ov1, co1, s1);
    end
  endtask

  task automatic test_w8_edges();
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; v8 = 1'b1;
    tick();
    total++;
    if ({ov8, s8, co8, of8} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL w8_wrap: got v=%b sum=%h co=%b ovf=%b required 1 00 1 0", ov8, s8, co8, of8);
    end
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
    tick();
    total++;
    if ({ov8, s8, co8, of8} !== {1'b1, 8'h80, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL w8_overflow: got v=%b sum=%h co=%b ovf=%b required 1 80 0 1", ov8, s8, co8, of8);
    end
    v8 = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic       tc [3];
    logic [9:0] te [3];
    ta = '{8'h10, 8'h80, 8'h0F};
    tb = '{8'h20, 8'h80, 8'hF0};
    tc = '{1'b0, 1'b0, 1'b1};
    te = '{{8'h30, 1'b0, 1'b0}, {8'h00, 1'b1, 1'b1}, {8'h00, 1'b1, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      a8 = ta[i]; b8 = tb[i]; c8 = tc[i]; v8 = 1'b1;
      tick();
      total++;
      if ({ov8, s8, co8, of8} !== {1'b1, te[i]}) begin
        bad++;
        $display("FAIL b2b_%0d: got v=%b sum=%h co=%b ovf=%b required 1 %h %b %b",
                 i, ov8, s8, co8, of8, te[i][9:2], te[i][1], te[i][0]);
      end
    end
    v8 = 1'b0;
    a8 = 8'h55; b8 = 8'h55;
    tick();
    total++;
    if ({ov8, s8, co8} !== {1'b0, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL b2b_hold: got v=%b sum=%h co=%b required 0 00 1", ov8, s8, co8);
    end
  endtask

  task automatic test_random_w16();
    logic [15:0] es;
    logic        eco, eovf;
    logic [16:0] full;
    int          errs;
    es = '0; eco = 1'b0; eovf = 1'b0; errs = 0;
    for (int i = 0; i < 10000; i++) begin
      v16 = 1'($urandom_range(0, 1));
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom_range(0, 1));
      if (v16) begin
        full = {1'b0, a16} + {1'b0, b16} + {16'd0, c16};
        es   = full[15:0];
        eco  = full[16];
        eovf = (a16[15] == b16[15]) && (full[15] != a16[15]);
      end
      tick();
      total++;
      if ({ov16, s16, co16, of16} !== {v16, es, eco, eovf}) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL rand_%0d: got v=%b sum=%h co=%b ovf=%b required %b %h %b %b",
                   i, ov16, s16, co16, of16, v16, es, eco, eovf);
      end
    end
    v16 = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
    #1;
    test_reset();
    test_truth_table();
    test_async_reset();
    test_w8_edges();
    test_back_to_back();
    test_random_w16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
